// File: rtl/arbiter_tdm_wc.sv
// rtl/arbiter_tdm_wc.sv - work-conserving TDM arbiter with programmable slot table
//
// Shares one downstream resource among N requesters. A slot table maps each
// time slot to an owner. An idle owner's slot can be reclaimed round-robin
// by the other requesters. A grant stays locked until done or the hold timeout.
//
// Ports:
//   clk          clock
//   aresetn      asynchronous active-low reset
//   i_req        per-requester level request
//   i_done       end-of-transaction pulse from the current grantee
//   i_cfg_we     slot table write enable
//   i_cfg_slot   slot index to write
//   i_cfg_owner  owner for that slot (value >= N marks the slot unowned)
//   o_grant      one-hot grant, registered
//   o_grant_id   index of the grantee, valid while |o_grant
//   o_reclaimed  current grant was issued in a slot not owned by the grantee
//   o_timeout    one-cycle pulse on forced release
//   o_slot       current slot counter value
module arbiter_tdm_wc #(
    parameter int N        = 4,
    parameter int SLOTS    = 16,
    parameter int RECLAIM  = 1,
    parameter int MAX_HOLD = 32
) (
    input  logic                       clk,
    input  logic                       aresetn,
    input  logic [N-1:0]               i_req,
    input  logic                       i_done,
    input  logic                       i_cfg_we,
    input  logic [$clog2(SLOTS)-1:0]   i_cfg_slot,
    input  logic [$clog2(N):0]         i_cfg_owner,
    output logic [N-1:0]               o_grant,
    output logic [$clog2(N)-1:0]       o_grant_id,
    output logic                       o_reclaimed,
    output logic                       o_timeout,
    output logic [$clog2(SLOTS)-1:0]   o_slot
);

    localparam int IW = $clog2(N);
    localparam int OW = IW + 1;
    localparam int SW = $clog2(SLOTS);
    localparam int HW = $clog2(MAX_HOLD);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t          state_q, state_d;
    logic [N-1:0]    grant_q, grant_d;
    logic [IW-1:0]   grant_id_q, grant_id_d;
    logic            reclaimed_q, reclaimed_d;
    logic            timeout_q, timeout_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [IW-1:0]   rr_q, rr_d;
    logic [HW-1:0]   hold_q, hold_d;
    logic [OW-1:0]   tbl_q [SLOTS];
    logic [OW-1:0]   tbl_d [SLOTS];

    // Arbitration helpers
    logic [OW-1:0]   cur_owner;
    logic            owner_valid;
    logic            owner_hit;
    logic            rr_found;
    logic [IW-1:0]   rr_win;
    logic [IW-1:0]   rr_idx;

    assign cur_owner   = tbl_q[slot_q];
    // An owner code of N or above (including MSB set) means nobody owns the slot.
    assign owner_valid = (int'(cur_owner) < N);
    assign owner_hit   = owner_valid && i_req[cur_owner[IW-1:0]];

    // Circular search for the first requester at or after the RR pointer.
    always_comb begin
        rr_found = 1'b0;
        rr_win   = '0;
        rr_idx   = '0;
        for (int k = 0; k < N; k++) begin
            rr_idx = IW'((int'(rr_q) + k) % N);
            if (!rr_found && i_req[rr_idx]) begin
                rr_found = 1'b1;
                rr_win   = rr_idx;
            end
        end
    end

    // Slot table: a write lands at the clock edge, so the slot being evaluated
    // in the write cycle still uses its old owner.
    always_comb begin
        for (int s = 0; s < SLOTS; s++) begin
            tbl_d[s] = tbl_q[s];
        end
        if (i_cfg_we) begin
            tbl_d[i_cfg_slot] = i_cfg_owner;
        end
    end

    assign slot_d = slot_q + SW'(1);

    always_comb begin
        state_d     = state_q;
        grant_d     = grant_q;
        grant_id_d  = grant_id_q;
        reclaimed_d = reclaimed_q;
        timeout_d   = 1'b0;
        rr_d        = rr_q;
        hold_d      = hold_q;

        case (state_q)
            IDLE: begin
                if (owner_hit) begin
                    grant_d                         = '0;
                    grant_d[cur_owner[IW-1:0]]      = 1'b1;
                    grant_id_d                      = cur_owner[IW-1:0];
                    reclaimed_d                     = 1'b0;
                    hold_d                          = '0;
                    state_d                         = BUSY;
                end else if ((RECLAIM != 0) && rr_found) begin
                    grant_d         = '0;
                    grant_d[rr_win] = 1'b1;
                    grant_id_d      = rr_win;
                    reclaimed_d     = 1'b1;
                    hold_d          = '0;
                    state_d         = BUSY;
                    // Pointer moves only on reclaim grants so owned slots do
                    // not disturb fairness among reclaimers.
                    rr_d = (int'(rr_win) == N - 1) ? '0 : rr_win + IW'(1);
                end
            end
            BUSY: begin
                hold_d = hold_q + HW'(1);
                if (i_done) begin
                    // Done wins over a simultaneous timeout.
                    grant_d     = '0;
                    grant_id_d  = '0;
                    reclaimed_d = 1'b0;
                    hold_d      = '0;
                    state_d     = IDLE;
                end else if (hold_q == HW'(MAX_HOLD - 1)) begin
                    grant_d     = '0;
                    grant_id_d  = '0;
                    reclaimed_d = 1'b0;
                    timeout_d   = 1'b1;
                    hold_d      = '0;
                    state_d     = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            grant_id_q  <= '0;
            reclaimed_q <= 1'b0;
            timeout_q   <= 1'b0;
            slot_q      <= '0;
            rr_q        <= '0;
            hold_q      <= '0;
            for (int s = 0; s < SLOTS; s++) begin
                tbl_q[s] <= OW'(s % N);
            end
        end else begin
            state_q     <= state_d;
            grant_q     <= grant_d;
            grant_id_q  <= grant_id_d;
            reclaimed_q <= reclaimed_d;
            timeout_q   <= timeout_d;
            slot_q      <= slot_d;
            rr_q        <= rr_d;
            hold_q      <= hold_d;
            for (int s = 0; s < SLOTS; s++) begin
                tbl_q[s] <= tbl_d[s];
            end
        end
    end

    assign o_grant     = grant_q;
    assign o_grant_id  = grant_id_q;
    assign o_reclaimed = reclaimed_q;
    assign o_timeout   = timeout_q;
    assign o_slot      = slot_q;

endmodule
